// File: rtl/link_wb_pipe.sv
// link_wb_pipe
//   Decodes link-writing control flow in ID (jal, jalr, bgezal, bltzal),
//   forms the link value pc + LINK_OFFSET and carries it through STAGES
//   pipeline registers to the register-file write port. In-flight link
//   values are forwarded to the ID operand readers.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   hold                freeze every pipeline stage this cycle
//   flush               load a bubble into stage 0 (wins over hold there)
//   id_valid            ID slot holds a real instruction
//   id_jal, id_jr       j-type / jr-type codes (10 = jal / jalr)
//   id_branch           branch code (0101 bgezal, 1000 bltzal)
//   id_rd               rd field, destination for jalr
//   id_pc               PC of the ID instruction
//   id_link             ID instruction writes a link register (combinational)
//   rs_addr, rt_addr    ID source register indices
//   fwd_r*_hit/_data    youngest in-flight link value matching rs / rt
//   wb_we/addr/data     link write at writeback, straight from last stage
//   busy                any stage holds a valid entry

module link_wb_pipe #(
    parameter int unsigned DW          = 32,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned LINK_OFFSET = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_jal,
    input  logic [1:0]    id_jr,
    input  logic [3:0]    id_branch,
    input  logic [4:0]    id_rd,
    input  logic [DW-1:0] id_pc,
    output logic          id_link,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic          fwd_rs_hit,
    output logic [DW-1:0] fwd_rs_data,
    output logic          fwd_rt_hit,
    output logic [DW-1:0] fwd_rt_data,
    output logic          wb_we,
    output logic [4:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          busy
);

    localparam logic [4:0]    LINK_RD  = 5'(LINK_REG);
    localparam logic [DW-1:0] LINK_OFF = DW'(LINK_OFFSET);

    localparam logic [1:0] JCODE_JAL   = 2'b10;
    localparam logic [1:0] JRCODE_JALR = 2'b10;
    localparam logic [3:0] BR_BGEZAL   = 4'b0101;
    localparam logic [3:0] BR_BLTZAL   = 4'b1000;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic          is_jalr;
    logic          link_any;
    logic [4:0]    dest;
    logic [DW-1:0] link_data;

    always_comb begin
        is_jalr   = (id_jr == JRCODE_JALR);
        link_any  = id_valid & ((id_jal == JCODE_JAL) | is_jalr |
                                (id_branch == BR_BGEZAL) |
                                (id_branch == BR_BLTZAL));
        dest      = is_jalr ? id_rd : LINK_RD;
        // Writes to r0 are architecturally void, so they never enter the pipe.
        id_link   = link_any & (dest != '0);
        link_data = id_pc + LINK_OFF;
    end

    // ------------------------------------------------------------------
    // Pipeline stages; index 0 is youngest, STAGES-1 feeds writeback
    // ------------------------------------------------------------------
    logic          v_q    [STAGES];
    logic [4:0]    addr_q [STAGES];
    logic [DW-1:0] data_q [STAGES];

    logic          v0_d;
    logic [4:0]    addr0_d;
    logic [DW-1:0] data0_d;

    // Stage 0 next value: flush beats hold, hold keeps, else capture ID.
    always_comb begin
        v0_d    = v_q[0];
        addr0_d = addr_q[0];
        data0_d = data_q[0];
        if (flush) begin
            v0_d    = 1'b0;
            addr0_d = '0;
            data0_d = '0;
        end else if (!hold) begin
            v0_d    = id_link;
            addr0_d = dest;
            data0_d = link_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i]    <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            v_q[0]    <= v0_d;
            addr_q[0] <= addr0_d;
            data_q[0] <= data0_d;
            if (!hold) begin
                for (int unsigned i = 1; i < STAGES; i++) begin
                    v_q[i]    <= v_q[i-1];
                    addr_q[i] <= addr_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: scan oldest to youngest so the youngest match wins
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        fwd_rs_hit  = 1'b0;
        fwd_rs_data = '0;
        fwd_rt_hit  = 1'b0;
        fwd_rt_data = '0;
        busy        = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            idx  = STAGES - 1 - k;
            busy = busy | v_q[idx];
            if (v_q[idx] && (rs_addr != '0) && (addr_q[idx] == rs_addr)) begin
                fwd_rs_hit  = 1'b1;
                fwd_rs_data = data_q[idx];
            end
            if (v_q[idx] && (rt_addr != '0) && (addr_q[idx] == rt_addr)) begin
                fwd_rt_hit  = 1'b1;
                fwd_rt_data = data_q[idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback: registered, straight from the last stage
    // ------------------------------------------------------------------
    assign wb_we   = v_q[STAGES-1];
    assign wb_addr = addr_q[STAGES-1];
    assign wb_data = data_q[STAGES-1];

endmodule
